mdu_rv32m_iter: RTL

Iterative multi-cycle multiply/divide unit executing all eight RV32M operations; it is the counterpart of the RV32I ALU on the M-extension side of the `MDSel` split. When the decoder asserts `MDSel`, the RV32I ALU drives zero and this block produces the result. It uses radix-2 shift-add multiplication and restoring division with a `Start`/`Busy`/`Done` handshake, so the core stalls while `Busy` is high.

---
 rtl/mdu_rv32m_iter.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/mdu_rv32m_iter.sv
// ============================================================================
//  Module   : mdu_rv32m_iter
//  Purpose  : Iterative RV32M multiply/divide unit. Radix-2 shift-add
//             multiply and restoring divide with a Start/Busy/Done handshake.
//             Every operation takes exactly WIDTH edges from Start to result.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module mdu_rv32m_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Start,
    input  logic [2:0]       MDControl,
    input  logic [WIDTH-1:0] Op1,
    input  logic [WIDTH-1:0] Op2,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] MDResult,
    output logic             Zero_M
);

    localparam int              c_CW       = $clog2(WIDTH) + 1;
    localparam logic [c_CW-1:0] c_CNT_LOAD = c_CW'(WIDTH);
    localparam logic [c_CW-1:0] c_CNT_ONE  = c_CW'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nx;
    logic [c_CW-1:0]    r_cnt;
    logic [2:0]         r_op;
    logic               r_neg;      // negate the selected result at the end
    logic [WIDTH-1:0]   r_m;        // multiplicand or divisor magnitude
    logic [WIDTH-1:0]   r_rem;      // partial remainder (divide only)
    logic [2*WIDTH-1:0] r_acc;      // product, or quotient in the low half
    logic [WIDTH-1:0]   r_result;

    logic               w_accept;
    logic               w_last;
    logic               w_sgn1;
    logic               w_sgn2;
    logic               w_neg1;
    logic               w_neg2;
    logic               w_neg_ld;
    logic [WIDTH-1:0]   w_mag1;
    logic [WIDTH-1:0]   w_mag2;
    logic [WIDTH:0]     w_sum;
    logic [2*WIDTH-1:0] w_mul_nx;
    logic [WIDTH:0]     w_shift;
    logic [WIDTH:0]     w_diff;
    logic               w_ge;
    logic [WIDTH-1:0]   w_rem_nx;
    logic [WIDTH-1:0]   w_q_nx;
    logic [2*WIDTH-1:0] w_acc_nx;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_q_s;
    logic [WIDTH-1:0]   w_r_s;
    logic [WIDTH-1:0]   w_result;

    assign w_accept = Start && (r_state != S_RUN);
    assign w_last   = (r_state == S_RUN) && (r_cnt == c_CNT_ONE);

    // Operand signedness, magnitudes and final-negate flag at latch time
    always_comb begin
        w_sgn1 = 1'b1;
        w_sgn2 = 1'b1;
        case (MDControl)
            3'b010:                 w_sgn2 = 1'b0;          // MULHSU
            3'b011, 3'b101, 3'b111: begin                   // unsigned ops
                w_sgn1 = 1'b0;
                w_sgn2 = 1'b0;
            end
            default: ;
        endcase
        w_neg1 = w_sgn1 & Op1[WIDTH-1];
        w_neg2 = w_sgn2 & Op2[WIDTH-1];
        w_mag1 = w_neg1 ? -Op1 : Op1;
        w_mag2 = w_neg2 ? -Op2 : Op2;
        // A zero divisor yields an all-ones quotient and a remainder equal to
        // |Op1|; suppressing the quotient negate gives -1, and the remainder
        // negate (dividend sign) restores Op1. Signed overflow also falls out
        // naturally: |MIN|/1 = MIN with no negate, remainder 0.
        if (!MDControl[2])
            w_neg_ld = w_neg1 ^ w_neg2;
        else if (MDControl[1])
            w_neg_ld = w_neg1;
        else
            w_neg_ld = (w_neg1 ^ w_neg2) & (|Op2);
    end

    // One multiply step and one restoring-divide step on the current state
    always_comb begin
        w_sum    = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_m};
        w_mul_nx = r_acc[0] ? {w_sum, r_acc[WIDTH-1:1]}
                            : {1'b0, r_acc[2*WIDTH-1:1]};
        w_shift  = {r_rem, r_acc[WIDTH-1]};
        w_diff   = w_shift - {1'b0, r_m};
        w_ge     = ~w_diff[WIDTH];
        w_rem_nx = w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
        w_q_nx   = {r_acc[WIDTH-2:0], w_ge};
        w_acc_nx = r_op[2] ? {r_acc[2*WIDTH-1:WIDTH], w_q_nx} : w_mul_nx;
    end

    // Sign fix-up and result selection from the final iteration's values
    always_comb begin
        w_prod = r_neg ? -w_mul_nx : w_mul_nx;
        w_q_s  = r_neg ? -w_q_nx   : w_q_nx;
        w_r_s  = r_neg ? -w_rem_nx : w_rem_nx;
        case (r_op)
            3'b000:                 w_result = w_prod[WIDTH-1:0];
            3'b001, 3'b010, 3'b011: w_result = w_prod[2*WIDTH-1:WIDTH];
            3'b100, 3'b101:         w_result = w_q_s;
            default:                w_result = w_r_s;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nx;
    end

    // Next-state logic
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE, S_DONE: w_state_nx = Start ? S_RUN : S_IDLE;
            S_RUN:          w_state_nx = w_last ? S_DONE : S_RUN;
            default:        w_state_nx = S_IDLE;
        endcase
    end

    // Datapath: latch operands on accept, iterate while running
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt    <= '0;
            r_op     <= '0;
            r_neg    <= 1'b0;
            r_m      <= '0;
            r_rem    <= '0;
            r_acc    <= '0;
            r_result <= '0;
        end else if (w_accept) begin
            r_cnt <= c_CNT_LOAD;
            r_op  <= MDControl;
            r_neg <= w_neg_ld;
            r_m   <= MDControl[2] ? w_mag2 : w_mag1;
            r_rem <= '0;
            r_acc <= {{WIDTH{1'b0}}, (MDControl[2] ? w_mag1 : w_mag2)};
        end else if (r_state == S_RUN) begin
            r_cnt <= r_cnt - c_CNT_ONE;
            r_acc <= w_acc_nx;
            r_rem <= w_rem_nx;
            if (w_last)
                r_result <= w_result;
        end
    end

    assign Busy     = (r_state == S_RUN);
    assign Done     = (r_state == S_DONE);
    assign MDResult = r_result;
    assign Zero_M   = (r_result == '0);

endmodule

`default_nettype wire
